bp_be_dcache_arbiter: RTL and testbench

Shares the single D$ request port between up to num_req_p requesters: the page-table walker, the pipe-mem load/store path, and a prefetch/flush engine. It grants one request per cycle and muxes the packet to the cache. One cycle after the grant it muxes the matching ptag from the granted owner. Two cycles after the grant it steers the early response back to that owner. It supports a walker-style lock, so a multi-level walk is not interleaved, and a starvation counter, so low-priority requesters are not locked out.

---
 rtl/bp_be_pkg.sv | 15 +
 rtl/bp_be_dcache_arb_prio.sv | 48 ++++
 rtl/bp_be_dcache_arbiter.sv | 148 ++++++++++++++
 tb/tb_bp_be_dcache_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bp_be_pkg : shared types for the backend D$ request arbiter         |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_idle   = 2'd0,
        e_locked = 2'd1,
        e_drain  = 2'd2
    } bp_be_dcache_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/bp_be_dcache_arb_prio.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bp_be_dcache_arb_prio : starvation-aware fixed-priority selector    |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module bsg_priority_encode_one_hot_out #(
    parameter int width_p = 1
) (
    input  logic [width_p-1:0] in_i,
    output logic [width_p-1:0] one_hot_o
);
    always_comb begin
        one_hot_o = '0;
        for (int k = 0; k < width_p; k++) begin
            if (in_i[k] && (one_hot_o == '0)) one_hot_o[k] = 1'b1;
        end
    end
endmodule

module bp_be_dcache_arb_prio
    import bp_be_pkg::*;
#(
    parameter int num_req_p = 3
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [num_req_p-1:0] starved_i,
    output logic [num_req_p-1:0] grant_o
);
    logic [num_req_p-1:0] w_starved_req;
    logic [num_req_p-1:0] w_pe_starved;
    logic [num_req_p-1:0] w_pe_req;

    assign w_starved_req = req_i & starved_i;

    bsg_priority_encode_one_hot_out #(.width_p(num_req_p)) u_pe_starved (
        .in_i      (w_starved_req),
        .one_hot_o (w_pe_starved)
    );

    bsg_priority_encode_one_hot_out #(.width_p(num_req_p)) u_pe_req (
        .in_i      (req_i),
        .one_hot_o (w_pe_req)
    );

    // Any starved requester pre-empts plain fixed priority.
    assign grant_o = (|w_starved_req) ? w_pe_starved : w_pe_req;
endmodule
`default_nettype wire

// File: rtl/bp_be_dcache_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bp_be_dcache_arbiter : shares the D$ request port among requesters  |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module bp_be_dcache_arbiter
    import bp_be_pkg::*;
#(
    parameter int  num_req_p      = 3,
    parameter int  pkt_width_p    = 96,
    parameter int  ptag_width_p   = 28,
    parameter int  starve_limit_p = 15,
    localparam int lg_req_lp      = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              flush_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p-1:0]              req_lock_i,
    input  logic [num_req_p*pkt_width_p-1:0]  req_pkt_i,
    input  logic [num_req_p-1:0]              req_ptag_v_i,
    input  logic [num_req_p*ptag_width_p-1:0] req_ptag_i,
    output logic [num_req_p-1:0]              req_grant_o,
    output logic                              dcache_pkt_v_o,
    output logic [pkt_width_p-1:0]            dcache_pkt_o,
    input  logic                              dcache_ready_i,
    output logic                              dcache_ptag_v_o,
    output logic [ptag_width_p-1:0]           dcache_ptag_o,
    input  logic                              dcache_early_v_i,
    output logic [num_req_p-1:0]              resp_v_o,
    output logic [lg_req_lp-1:0]              lock_owner_o,
    output logic                              locked_o
);
    localparam int cnt_width_lp = (starve_limit_p > 0) ? $clog2(starve_limit_p + 1) : 1;
    localparam logic [cnt_width_lp-1:0] c_starve_limit = cnt_width_lp'(starve_limit_p);

    typedef struct packed {
        logic                 v;
        logic [lg_req_lp-1:0] idx;
    } bp_be_dcache_arbiter_owner_s;

    bp_be_dcache_arb_state_e     state_q, state_d;
    logic [lg_req_lp-1:0]        lock_owner_q, lock_owner_d;
    logic                        locked_q, locked_d;
    bp_be_dcache_arbiter_owner_s stage1_q, stage1_d, stage2_q, stage2_d;
    logic [cnt_width_lp-1:0]     cnt_q [num_req_p];

    logic [num_req_p-1:0]    w_owner_oh, w_cand, w_starved, w_prio_grant, w_grant;
    logic [lg_req_lp-1:0]    w_grant_idx;
    logic                    w_grant_any, w_grant_lock, w_ptag_v;
    logic [ptag_width_p-1:0] w_ptag;

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
        assign w_owner_oh[gi] = (lock_owner_q == lg_req_lp'(gi));
        assign w_starved[gi]  = (cnt_q[gi] >= c_starve_limit);
    end

    always_comb begin
        w_cand = '0;
        case (state_q)
            e_idle:   w_cand = req_v_i;
            e_locked: w_cand = req_v_i & w_owner_oh;
            default:  w_cand = '0;
        endcase
    end

    bp_be_dcache_arb_prio #(.num_req_p(num_req_p)) u_prio (
        .req_i     (w_cand),
        .starved_i (w_starved),
        .grant_o   (w_prio_grant)
    );

    // Grant is gated by reset so outputs are quiet while reset is held.
    assign w_grant      = (dcache_ready_i && reset_n_i) ? w_prio_grant : '0;
    assign w_grant_any  = |w_grant;
    assign w_grant_lock = |(w_grant & req_lock_i);

    always_comb begin
        dcache_pkt_o = '0;
        w_grant_idx  = '0;
        w_ptag_v     = 1'b0;
        w_ptag       = '0;
        resp_v_o     = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (w_grant[i]) begin
                dcache_pkt_o = dcache_pkt_o | req_pkt_i[i*pkt_width_p +: pkt_width_p];
                w_grant_idx  = lg_req_lp'(i);
            end
            if (stage1_q.v && (stage1_q.idx == lg_req_lp'(i))) begin
                w_ptag_v = req_ptag_v_i[i];
                w_ptag   = req_ptag_i[i*ptag_width_p +: ptag_width_p];
            end
            if (stage2_q.v && (stage2_q.idx == lg_req_lp'(i)))
                resp_v_o[i] = dcache_early_v_i & ~flush_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        case (state_q)
            e_idle: begin
                if (w_grant_any && w_grant_lock) begin
                    state_d      = e_locked;
                    lock_owner_d = w_grant_idx;
                end
            end
            e_locked: if (w_grant_any && !w_grant_lock) state_d = e_drain;
            // Leave once nothing will be in stage 2 on the next cycle.
            e_drain:  if (!(stage1_q.v && !flush_i)) state_d = e_idle;
            default:  state_d = e_idle;
        endcase
        locked_d = (state_d == e_locked);
        stage1_d = '{v: w_grant_any & ~flush_i, idx: w_grant_idx};
        stage2_d = '{v: stage1_q.v & ~flush_i, idx: stage1_q.idx};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= e_idle;
            lock_owner_q <= '0;
            locked_q     <= 1'b0;
            stage1_q     <= '0;
            stage2_q     <= '0;
            for (int i = 0; i < num_req_p; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            locked_q     <= locked_d;
            stage1_q     <= stage1_d;
            stage2_q     <= stage2_d;
            for (int i = 0; i < num_req_p; i++) begin
                if (!req_v_i[i] || w_grant[i])
                    cnt_q[i] <= '0;
                else if (cnt_q[i] != c_starve_limit)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign req_grant_o     = w_grant;
    assign dcache_pkt_v_o  = w_grant_any;
    assign dcache_ptag_v_o = w_ptag_v & ~flush_i;
    assign dcache_ptag_o   = w_ptag;
    assign lock_owner_o    = lock_owner_q;
    assign locked_o        = locked_q;
endmodule
`default_nettype wire

// File: tb/tb_bp_be_dcache_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_bp_be_dcache_arbiter : scoreboard bench for the D$ arbiter       |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_bp_be_dcache_arbiter;

    logic         clk;
    logic         reset_n_i;
    logic         flush_i;
    logic [2:0]   req_v_i;
    logic [2:0]   req_lock_i;
    logic [287:0] req_pkt_i;
    logic [2:0]   req_ptag_v_i;
    logic [83:0]  req_ptag_i;
    logic [2:0]   req_grant_o;
    logic         dcache_pkt_v_o;
    logic [95:0]  dcache_pkt_o;
    logic         dcache_ready_i;
    logic         dcache_ptag_v_o;
    logic [27:0]  dcache_ptag_o;
    logic         dcache_early_v_i;
    logic [2:0]   resp_v_o;
    logic [1:0]   lock_owner_o;
    logic         locked_o;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
        logic [95:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t pq[$];
    exp_t rq[$];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [95:0] pkt_of(input int k);
        case (k)
            0:       return 96'hA0A0_0000_1111_2222_3333_0001;
            1:       return 96'hB1B1_4444_5555_6666_7777_0002;
            default: return 96'hC2C2_8888_9999_AAAA_BBBB_0003;
        endcase
    endfunction

    function automatic logic [27:0] ptag_of(input int k);
        case (k)
            0:       return 28'hA00_0001;
            1:       return 28'hB00_0002;
            default: return 28'hC00_0003;
        endcase
    endfunction

    assign req_pkt_i  = {pkt_of(2), pkt_of(1), pkt_of(0)};
    assign req_ptag_i = {ptag_of(2), ptag_of(1), ptag_of(0)};

    bp_be_dcache_arbiter dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .flush_i          (flush_i),
        .req_v_i          (req_v_i),
        .req_lock_i       (req_lock_i),
        .req_pkt_i        (req_pkt_i),
        .req_ptag_v_i     (req_ptag_v_i),
        .req_ptag_i       (req_ptag_i),
        .req_grant_o      (req_grant_o),
        .dcache_pkt_v_o   (dcache_pkt_v_o),
        .dcache_pkt_o     (dcache_pkt_o),
        .dcache_ready_i   (dcache_ready_i),
        .dcache_ptag_v_o  (dcache_ptag_v_o),
        .dcache_ptag_o    (dcache_ptag_o),
        .dcache_early_v_i (dcache_early_v_i),
        .resp_v_o         (resp_v_o),
        .lock_owner_o     (lock_owner_o),
        .locked_o         (locked_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic exp_grant(input int k, input bit ptag_ok, input bit resp_ok);
        exp_t e;
        e.cyc  = cyc;
        e.vec  = 3'(1 << k);
        e.data = pkt_of(k);
        gq.push_back(e);
        if (ptag_ok) begin
            e.cyc  = cyc + 1;
            e.data = 96'(ptag_of(k));
            pq.push_back(e);
        end
        if (resp_ok) begin
            e.cyc  = cyc + 2;
            e.data = '0;
            rq.push_back(e);
        end
    endtask

    // Requesters drive ptag valid the cycle after their grant; the D$
    // answers every accepted packet two cycles after acceptance.
    initial begin
        logic [2:0] g_s;
        logic       h1;
        g_s              = '0;
        h1               = 1'b0;
        req_ptag_v_i     = '0;
        dcache_early_v_i = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n_i) begin
                g_s = req_grant_o;
            end else begin
                g_s = '0;
                h1  = 1'b0;
            end
            @(posedge clk);
            #1;
            req_ptag_v_i     = g_s;
            dcache_early_v_i = h1;
            h1               = |g_s;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n_i) begin
                while (gq.size() > 0 && gq[0].cyc < cyc) begin
                    e = gq.pop_front();
                    check("grant_missed", 128'(cyc), 128'(e.cyc));
                end
                while (pq.size() > 0 && pq[0].cyc < cyc) begin
                    e = pq.pop_front();
                    check("ptag_missed", 128'(cyc), 128'(e.cyc));
                end
                while (rq.size() > 0 && rq[0].cyc < cyc) begin
                    e = rq.pop_front();
                    check("resp_missed", 128'(cyc), 128'(e.cyc));
                end

                if (dcache_pkt_v_o) begin
                    if (gq.size() == 0) begin
                        check("grant_unexpected", 128'(dcache_pkt_v_o), '0);
                    end else begin
                        e = gq.pop_front();
                        check("grant_cycle", 128'(cyc), 128'(e.cyc));
                        check("grant_vec", 128'(req_grant_o), 128'(e.vec));
                        check("grant_pkt", 128'(dcache_pkt_o), 128'(e.data));
                    end
                end else begin
                    check("nogrant_vec", 128'(req_grant_o), '0);
                    check("nogrant_pkt", 128'(dcache_pkt_o), '0);
                end

                if (dcache_ptag_v_o) begin
                    if (pq.size() == 0) begin
                        check("ptag_unexpected", 128'(dcache_ptag_v_o), '0);
                    end else begin
                        e = pq.pop_front();
                        check("ptag_cycle", 128'(cyc), 128'(e.cyc));
                        check("ptag_data", 128'(dcache_ptag_o), 128'(e.data));
                    end
                end

                if (resp_v_o != 3'b000) begin
                    if (rq.size() == 0) begin
                        check("resp_unexpected", 128'(resp_v_o), '0);
                    end else begin
                        e = rq.pop_front();
                        check("resp_cycle", 128'(cyc), 128'(e.cyc));
                        check("resp_vec", 128'(resp_v_o), 128'(e.vec));
                    end
                end
            end
        end
    end

    initial begin
        reset_n_i      = 1'b0;
        flush_i        = 1'b0;
        req_v_i        = 3'b111;
        req_lock_i     = 3'b000;
        dcache_ready_i = 1'b1;

        // Reset: outputs quiet even with all requests pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant",   128'(req_grant_o), '0);
        check("rst_pkt_v",   128'(dcache_pkt_v_o), '0);
        check("rst_pkt",     128'(dcache_pkt_o), '0);
        check("rst_ptag_v",  128'(dcache_ptag_v_o), '0);
        check("rst_ptag",    128'(dcache_ptag_o), '0);
        check("rst_resp",    128'(resp_v_o), '0);
        check("rst_locked",  128'(locked_o), '0);
        check("rst_owner",   128'(lock_owner_o), '0);

        // First grant goes to requester 0, ptag +1, response +2.
        tick(); reset_n_i = 1'b1; exp_grant(0, 1, 1);
        tick(); req_v_i = 3'b000;
        idle(3);

        // Locked walk by requester 0 while requester 1 waits.
        tick(); req_v_i = 3'b011; req_lock_i = 3'b001; exp_grant(0, 1, 1);
        tick(); exp_grant(0, 1, 1);
        @(negedge clk);
        check("lock_locked", 128'(locked_o), 128'(1));
        check("lock_owner",  128'(lock_owner_o), 128'(0));
        tick(); req_v_i = 3'b010;
        @(negedge clk);
        check("lock_hold_on_drop", 128'(locked_o), 128'(1));
        tick(); req_v_i = 3'b011; exp_grant(0, 1, 1);
        tick(); req_lock_i = 3'b000; exp_grant(0, 1, 1);
        tick(); req_v_i = 3'b010;
        @(negedge clk);
        check("drain_unlocked", 128'(locked_o), '0);
        check("drain_nogrant",  128'(req_grant_o), '0);
        tick();
        tick(); exp_grant(1, 1, 1);
        tick(); req_v_i = 3'b000;
        idle(3);

        // Starvation: requester 2 wins after 15 waiting cycles.
        tick(); req_v_i = 3'b101; exp_grant(0, 1, 1);
        for (int i = 1; i < 15; i++) begin
            tick(); exp_grant(0, 1, 1);
        end
        tick(); exp_grant(2, 1, 1);
        tick(); exp_grant(0, 1, 1);
        tick(); exp_grant(0, 1, 1);
        tick(); req_v_i = 3'b000;
        idle(3);

        // D$ back-pressure for five cycles.
        tick(); req_v_i = 3'b010; dcache_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_pkt_v", 128'(dcache_pkt_v_o), '0);
            tick();
        end
        dcache_ready_i = 1'b1; exp_grant(1, 1, 1);
        tick(); req_v_i = 3'b000;
        idle(3);

        // Flush one cycle after a grant kills ptag valid and response.
        tick(); req_v_i = 3'b010; exp_grant(1, 0, 0);
        tick(); req_v_i = 3'b000; flush_i = 1'b1;
        @(negedge clk);
        check("flush_ptag_v", 128'(dcache_ptag_v_o), '0);
        tick(); flush_i = 1'b0;
        @(negedge clk);
        check("flush_resp", 128'(resp_v_o), '0);
        idle(3);

        // Asynchronous reset in the middle of a locked walk.
        tick(); req_v_i = 3'b010; req_lock_i = 3'b010; exp_grant(1, 0, 0);
        tick();
        check("walk_locked", 128'(locked_o), 128'(1));
        #1; reset_n_i = 1'b0;
        #1;
        check("arst_locked",  128'(locked_o), '0);
        check("arst_owner",   128'(lock_owner_o), '0);
        check("arst_grant",   128'(req_grant_o), '0);
        check("arst_pkt_v",   128'(dcache_pkt_v_o), '0);
        check("arst_ptag_v",  128'(dcache_ptag_v_o), '0);
        check("arst_resp",    128'(resp_v_o), '0);
        req_v_i = 3'b110; req_lock_i = 3'b000;
        tick();
        tick(); reset_n_i = 1'b1; exp_grant(1, 1, 1);
        tick(); req_v_i = 3'b000;
        idle(4);

        check("gq_drained", 128'(gq.size()), '0);
        check("pq_drained", 128'(pq.size()), '0);
        check("rq_drained", 128'(rq.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
